// File: rtl/alu_pkg.sv
// Shared widths, idle defaults, FIFO entry type and issue-state encoding
// for the ALU operand-issue stage.
package alu_pkg;

    localparam int OPW   = 3;
    localparam int WIDTH = 4;

    localparam logic [OPW-1:0] IDLE_OPCODE = 3'b000;

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
    } alu_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// Circular request buffer for the issue stage; DEPTH must be a power of two
// so the read/write pointers wrap by plain overflow.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  alu_req_t                 wdata_i,
    output alu_req_t                 rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    alu_req_t      mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i && !full_o;
    assign do_pop  = pop_i  && !flush_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: buffers ALU requests and presents each one on
// registered OPCODE/OP1/OP2 for HOLD_CYCLES cycles.
//
//   state | meaning
//   IDLE  | no operation on the ALU inputs, idle pattern driven
//   ISSUE | an operation is held on the ALU inputs, hold counter running
module alu_issue
    import alu_pkg::*;
#(
    parameter int              WIDTH       = alu_pkg::WIDTH,
    parameter int              OPW         = alu_pkg::OPW,
    parameter int              DEPTH       = 4,
    parameter int              HOLD_CYCLES = 2,
    parameter logic [OPW-1:0]  IDLE_OPCODE = alu_pkg::IDLE_OPCODE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_opcode,
    input  logic [WIDTH-1:0]         in_op1,
    input  logic [WIDTH-1:0]         in_op2,
    input  logic                     flush,
    output logic [OPW-1:0]           OPCODE,
    output logic [WIDTH-1:0]         OP1,
    output logic [WIDTH-1:0]         OP2,
    output logic                     issue_strobe,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

    issue_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;

    alu_req_t push_req;
    alu_req_t head_req;
    logic     push;
    logic     pop;
    logic     load;
    logic     fifo_empty;
    logic     fifo_full;

    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;

    always_comb begin
        push_req        = '0;
        push_req.opcode = in_opcode;
        push_req.op1    = in_op1;
        push_req.op2    = in_op2;
    end

    alu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_req),
        .rdata_o (head_req),
        .level_o (level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        pop      = 1'b0;
        load     = 1'b0;

        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            opcode_d = IDLE_OPCODE;
            op1_d    = '0;
            op2_d    = '0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    load = !fifo_empty;
                end
                ISSUE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        opcode_d = IDLE_OPCODE;
                        op1_d    = '0;
                        op2_d    = '0;
                        busy_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                state_d  = ISSUE;
                cnt_d    = HOLD_RELOAD;
                opcode_d = head_req.opcode;
                op1_d    = head_req.op1;
                op2_d    = head_req.op2;
                strobe_d = 1'b1;
                busy_d   = 1'b1;
                pop      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opcode_q <= IDLE_OPCODE;
            op1_q    <= '0;
            op2_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    assign OPCODE       = opcode_q;
    assign OP1          = op1_q;
    assign OP2          = op2_q;
    assign issue_strobe = strobe_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: random and directed stimulus against a queue-based
// reference model, plus a HOLD_CYCLES=1 instance exercised directly.
`timescale 1ns/1ps
module tb_alu_issue;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, flush;
    logic [2:0] in_opcode;
    logic [3:0] in_op1, in_op2;
    logic [2:0] OPCODE;
    logic [3:0] OP1, OP2;
    logic       issue_strobe, busy;
    logic [2:0] level;

    logic       b_in_valid, b_in_ready, b_flush;
    logic [2:0] b_in_opcode;
    logic [3:0] b_in_op1, b_in_op2;
    logic [2:0] b_OPCODE;
    logic [3:0] b_OP1, b_OP2;
    logic       b_issue_strobe, b_busy;
    logic [2:0] b_level;

    alu_issue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .flush(flush),
        .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .issue_strobe(issue_strobe),
        .busy(busy), .level(level)
    );

    alu_issue #(.DEPTH(DEPTH), .HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_opcode(b_in_opcode), .in_op1(b_in_op1), .in_op2(b_in_op2), .flush(b_flush),
        .OPCODE(b_OPCODE), .OP1(b_OP1), .OP2(b_OP2), .issue_strobe(b_issue_strobe),
        .busy(b_busy), .level(b_level)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ops wait in a queue in arrival order; an op leaves the
    // queue when the ALU inputs are free and then occupies them for HOLD cycles.
    typedef struct {
        logic [2:0] opc;
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    op_t exp_q[$];
    op_t cur;
    op_t pend_op;
    int  remaining  = 0;
    bit  pend_push  = 0;
    bit  pend_flush = 0;
    bit  exp_strobe = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            remaining  = 0;
            pend_push  = 0;
            pend_flush = 0;
            chk("rst_opcode",   OPCODE, 0);
            chk("rst_op1",      OP1, 0);
            chk("rst_op2",      OP2, 0);
            chk("rst_strobe",   issue_strobe, 0);
            chk("rst_busy",     busy, 0);
            chk("rst_level",    level, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            exp_strobe = 0;
            if (pend_flush) begin
                exp_q.delete();
                remaining = 0;
            end else begin
                if (remaining > 1) begin
                    remaining--;
                end else if (exp_q.size() > 0) begin
                    cur        = exp_q.pop_front();
                    remaining  = HOLD;
                    exp_strobe = 1;
                end else begin
                    remaining = 0;
                end
                if (pend_push) exp_q.push_back(pend_op);
            end
            chk("strobe",   issue_strobe, exp_strobe);
            chk("busy",     busy, remaining > 0);
            chk("opcode",   OPCODE, (remaining > 0) ? cur.opc : 3'b000);
            chk("op1",      OP1, (remaining > 0) ? cur.a : 4'd0);
            chk("op2",      OP2, (remaining > 0) ? cur.b : 4'd0);
            chk("level",    level, exp_q.size());
            chk("in_ready", in_ready, (exp_q.size() < DEPTH) && !flush);
            pend_flush = flush;
            pend_push  = in_valid && (exp_q.size() < DEPTH) && !flush;
            pend_op    = '{in_opcode, in_op1, in_op2};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Presents one request and keeps it until accepted; leaves in_valid high.
    task automatic push_op(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
        bit ok;
        ok        = 0;
        in_valid  = 1'b1;
        in_opcode = opc;
        in_op1    = a;
        in_op2    = b;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("push_timeout", 0, 1);
        tick();
    endtask

    task automatic chk_b(input string name, input op_t e, input logic strobe_e, input int lvl_e);
        chk({name, "_opcode"}, b_OPCODE, e.opc);
        chk({name, "_op1"},    b_OP1, e.a);
        chk({name, "_op2"},    b_OP2, e.b);
        chk({name, "_strobe"}, b_issue_strobe, strobe_e);
        chk({name, "_busy"},   b_busy, strobe_e);
        chk({name, "_level"},  b_level, lvl_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t bops[3];
        op_t idle_op;
        bit  seen;

        in_valid = 0; flush = 0; in_opcode = 0; in_op1 = 0; in_op2 = 0;
        b_in_valid = 0; b_flush = 0; b_in_opcode = 0; b_in_op1 = 0; b_in_op2 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // single op, then idle pattern after two cycles
        push_op(3'b010, 4'd0, 4'd0);
        idle(6);

        // fill until full while the pop side is holding
        for (int i = 0; i < 8; i++) push_op(3'($urandom), 4'($urandom), 4'($urandom));
        idle(20);

        // order across pointer wrap
        for (int i = 0; i < 10; i++) push_op(3'($urandom), 4'(i), 4'($urandom));
        idle(25);

        // flush in ISSUE with three queued and a concurrent push
        for (int i = 0; i < 5; i++) push_op(3'($urandom_range(1, 7)), 4'($urandom), 4'($urandom));
        chk("pre_flush_level", level, 3);
        chk("pre_flush_busy", busy, 1);
        in_valid  = 1'b1;
        in_opcode = 3'b111;
        in_op1    = 4'hF;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("post_flush_level", level, 0);
        chk("post_flush_busy", busy, 0);
        chk("post_flush_opcode", OPCODE, 0);
        idle(10);

        // async reset mid-hold
        push_op(3'b110, 4'($urandom), 4'($urandom));
        in_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (issue_strobe) begin
                seen = 1;
                break;
            end
        end
        chk("rst_wait_strobe", seen, 1);
        chk("pre_rst_opcode", OPCODE, 3'b110);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_opcode", OPCODE, 0);
        chk("async_rst_op1", OP1, 0);
        chk("async_rst_op2", OP2, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_strobe", issue_strobe, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        push_op(3'b101, 4'd3, 4'd4);
        idle(6);

        // random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_opcode = 3'($urandom);
            in_op1    = 4'($urandom);
            in_op2    = 4'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        idle(20);

        // HOLD_CYCLES=1 instance: three back-to-back ops
        idle_op = '{3'b000, 4'd0, 4'd0};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                bops[0] = '{3'b001, 4'b0001, 4'b0010};
                bops[1] = '{3'b011, 4'b1110, 4'b0001};
                bops[2] = '{3'b101, 4'b1111, 4'b1111};
            end else begin
                for (int k = 0; k < 3; k++)
                    bops[k] = '{3'($urandom_range(1, 7)), 4'($urandom), 4'($urandom)};
            end
            b_in_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                b_in_opcode = bops[k].opc;
                b_in_op1    = bops[k].a;
                b_in_op2    = bops[k].b;
                tick();
                if (k == 0) chk_b("h1_accept", idle_op, 1'b0, 1);
                else        chk_b("h1_issue", bops[k-1], 1'b1, 1);
            end
            b_in_valid = 1'b0;
            tick();
            chk_b("h1_last", bops[2], 1'b1, 0);
            tick();
            chk_b("h1_idle", idle_op, 1'b0, 0);
            repeat (2) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
